// File: rtl/sum_pkg.sv
// sum_pkg: shared FSM encoding and default operand width for the bit-serial adder
package sum_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/sum1bcc.sv
// sum1bcc: 1-bit full adder
//   A, B, Ci : operand bits and carry-in
//   S, Co    : sum bit and carry-out
module sum1bcc (
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic S,
    output logic Co
);
    assign S  = A ^ B ^ Ci;
    assign Co = (A & B) | (Ci & (A ^ B));
endmodule

// File: rtl/sum_serie_ctrl.sv
// sum_serie_ctrl: bit-serial adder computing {Cout,S} = A + B + Ci, one bit per clock, LSB first
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin an addition (sampled only in IDLE)
//   A, B, Ci    : operands, captured on the accepting edge
//   busy        : high for the WIDTH cycles of RUN
//   done        : one-cycle pulse when S/Cout carry a new result
//   S, Cout     : registered result, updated only on completion
module sum_serie_ctrl
    import sum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [WIDTH-1:0] r_a, r_b, r_res;
    logic r_c, w_s, w_co;
    logic w_last;
    sum1bcc u_fa (
        .A (r_a[0]),
        .B (r_b[0]),
        .Ci(r_c),
        .S (w_s),
        .Co(w_co)
    );
    assign w_last = (r_cnt == LAST);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    // The unused encoding falls back to IDLE.
    always_comb begin
        w_next = IDLE;
        busy   = 1'b0;
        done   = 1'b0;
        w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
                 (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
        busy   = (r_state == RUN);
        done   = (r_state == DONE);
    end
    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 holds the first (LSB) sum bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= 1'b0;
            r_res <= '0;
            r_cnt <= '0;
            S     <= '0;
            Cout  <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_a   <= A;
            r_b   <= B;
            r_c   <= Ci;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_res <= {w_s, r_res[WIDTH-1:1]};
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_c   <= w_co;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                S    <= {w_s, r_res[WIDTH-1:1]};
                Cout <= w_co;
            end
        end
    end
endmodule

// File: doc/sum_serie_ctrl.md
SUM_SERIE_CTRL -- requirements
Module: sum_serie_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have port A  input  WIDTH  operand A; captured on the edge that accepts start.
REQ-006 The block SHALL have port B  input  WIDTH  operand B; captured on the edge that accepts start.
REQ-007 The block SHALL have port Ci  input  1  carry-in; captured on the edge that accepts start.
REQ-008 The block SHALL have port busy  output  1  high while the bit-serial operation runs.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking a valid new result.
REQ-010 The block SHALL have port S  output  WIDTH  registered sum result.
REQ-011 The block SHALL have port Cout  output  1  registered final carry-out.

Function
REQ-012 The block SHALL compute {Cout,S} = A + B + Ci, one bit per clock cycle, LSB first, through a single 1-bit full adder.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE with start=1, the edge SHALL load A, B and Ci into internal shift and carry registers, clear the bit counter, and enter RUN.
REQ-015 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-016 Each RUN edge SHALL feed the full adder with the A/B shift-register LSBs and the carry register.
REQ-017 Each RUN edge SHALL shift the sum bit into the result register MSB, shift A and B right one place, store the carry-out in the carry register, and increment the counter.
REQ-018 On the RUN edge with counter = WIDTH-1, the block SHALL load S from the completed result, load Cout from the final carry, and enter DONE.
REQ-019 RUN SHALL last exactly WIDTH cycles, with busy = 1 throughout and only in RUN.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-021 Measured from the accepting edge, the block SHALL assert done WIDTH cycles later; an accepted start SHALL be followed by at least WIDTH+2 cycles before the next accept.
REQ-022 S and Cout SHALL hold the previous result during RUN and until the next completion, changing only on the RUN-to-DONE edge.
REQ-023 The block SHALL ignore start in RUN and DONE; an asserted start SHALL NOT queue an operation.
REQ-024 A start held high continuously SHALL be accepted again on the first IDLE edge after DONE.
REQ-025 A, B and Ci SHALL be don't-care after capture; changes during RUN SHALL NOT affect the result.

Reset
REQ-026 While rst_n = 0, the FSM SHALL be IDLE and busy, done, S, Cout, the counter, the shift registers and the carry register SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL abort the operation immediately, with no done pulse and no update of S or Cout.
REQ-028 After rst_n deasserts, the first rising edge SHALL already be able to accept start.

Structure
REQ-029 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH SHALL live in the shared package sum_pkg.
REQ-030 The counter width SHALL be $clog2(WIDTH) bits.
REQ-031 The block SHALL instantiate the existing 1-bit full adder sum1bcc as its only sub-module, with no other arithmetic on the datapath.
REQ-032 All outputs SHALL be driven from registers or from decoded FSM state only.

Verification
REQ-033 Scenario 1: WIDTH=8, A=0x5A, B=0x3C, Ci=0, start for one cycle -> busy for 8 cycles, then a single done, S=0x96, Cout=0.
REQ-034 Scenario 2: A=0xFF, B=0x01, Ci=0 -> S=0x00, Cout=1; A=0xFF, B=0xFF, Ci=1 -> S=0xFF, Cout=1.
REQ-035 Scenario 3: after a completed operation (S=0x96), start A=0x01, B=0x01, pulse start again at RUN cycle 3, and toggle A during RUN -> S holds 0x96 during RUN, then one operation gives S=0x02, with no second done.
REQ-036 Scenario 4: pull rst_n low at RUN cycle 4 of A=0x0F, B=0x0F -> busy=0, done never pulses, S=0x00, Cout=0; a new start after release completes normally.
REQ-037 Scenario 5: start held high across three operations -> done pulses spaced exactly WIDTH+2 cycles apart, each with the correct sum.
REQ-038 Scenario 6: random A, B and Ci (at least 1000 operations), checked against a reference model A+B+Ci at each done -> zero mismatches.
